// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the multicycle MIPS core slice.
//   mult_state_t : control states of the sequential Booth multiplier
//   MULT_WIDTH   : default operand width of the multiplier
package mips_pkg;

   typedef enum logic [1:0] {
      MULT_IDLE,
      MULT_RUN,
      MULT_DONE
   } mult_state_t;

   localparam int unsigned MULT_WIDTH = 32;

endpackage : mips_pkg

// File: rtl/booth_step.sv
// booth_step: one combinational radix-2 Booth iteration.
//   acc, q, q_1, m        : current accumulator, multiplier register, guard bit, multiplicand
//   acc_next, q_next,
//   q_1_next              : state after the add/sub and the arithmetic right shift
// Parameters: WIDTH (operand width, acc/m are WIDTH+1 bits), QW (multiplier register width).
module booth_step
   import mips_pkg::*;
#(
   parameter int unsigned WIDTH = MULT_WIDTH,
   parameter int unsigned QW    = MULT_WIDTH
) (
   input  logic [WIDTH:0]  acc,
   input  logic [QW-1:0]   q,
   input  logic            q_1,
   input  logic [WIDTH:0]  m,
   output logic [WIDTH:0]  acc_next,
   output logic [QW-1:0]   q_next,
   output logic            q_1_next
);

   logic [WIDTH:0] sum;

   always_comb begin
      sum = acc;
      unique case ({q[0], q_1})
         2'b01:   sum = acc + m;
         2'b10:   sum = acc - m;
         default: sum = acc;
      endcase
      // Arithmetic shift of {sum,q,q_1}: sign bit replicated, q_1 falls off.
      {acc_next, q_next, q_1_next} = {sum[WIDTH], sum, q};
   end

endmodule : booth_step

// File: rtl/booth_mult_unit.sv
// booth_mult_unit: sequential radix-2 Booth multiplier (MULT, optionally MULTU).
// One add/sub plus shift per cycle; done pulses one cycle when product is valid.
// Ports:
//   Clk          core clock (rising edge)
//   reset        synchronous, active-high
//   start        multiply request, sampled only in IDLE
//   is_unsigned  1 = MULTU (only when MULT_UNSIGNED_EN is defined)
//   oper_A       multiplicand (rs)
//   oper_B       multiplier (rt)
//   busy         high in RUN and DONE
//   done         one-cycle product-valid pulse
//   product      {HI,LO}, held until the next accepted start
// Configuration macro: MULT_UNSIGNED_EN adds is_unsigned and the 33-iteration unsigned mode.
module booth_mult_unit
   import mips_pkg::*;
#(
   parameter int unsigned WIDTH = MULT_WIDTH
) (
   input  logic                 Clk,
   input  logic                 reset,
   input  logic                 start,
`ifdef MULT_UNSIGNED_EN
   input  logic                 is_unsigned,
`endif
   input  logic [WIDTH-1:0]     oper_A,
   input  logic [WIDTH-1:0]     oper_B,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

`ifdef MULT_UNSIGNED_EN
   // Extra multiplier bit carries the zero-extension for MULTU.
   localparam int unsigned QW = WIDTH + 1;
   localparam int unsigned CW = $clog2(WIDTH + 1);
`else
   localparam int unsigned QW = WIDTH;
   localparam int unsigned CW = $clog2(WIDTH);
`endif

   mult_state_t          state;
   logic [WIDTH:0]       acc;
   logic [WIDTH:0]       m;
   logic [QW-1:0]        q;
   logic                 q_1;
   logic [CW-1:0]        count;
   logic [CW-1:0]        last_count;
   logic [WIDTH:0]       acc_nx;
   logic [QW-1:0]        q_nx;
   logic                 q_1_nx;
   logic [2*WIDTH-1:0]   prod_nx;
   logic [WIDTH:0]       m_load;
   logic [QW-1:0]        q_load;

`ifdef MULT_UNSIGNED_EN
   logic                 unsigned_q;

   assign m_load     = is_unsigned ? {1'b0, oper_A} : {oper_A[WIDTH-1], oper_A};
   assign q_load     = {~is_unsigned & oper_B[WIDTH-1], oper_B};
   assign last_count = unsigned_q ? CW'(WIDTH) : CW'(WIDTH - 1);
   // Signed mode stops one shift short, so the untouched top q bit sits at q_nx[0].
   assign prod_nx    = unsigned_q ? {acc_nx[WIDTH-2:0], q_nx}
                                  : {acc_nx[WIDTH-1:0], q_nx[QW-1:1]};
`else
   assign m_load     = {oper_A[WIDTH-1], oper_A};
   assign q_load     = oper_B;
   assign last_count = CW'(WIDTH - 1);
   assign prod_nx    = {acc_nx[WIDTH-1:0], q_nx};
`endif

   booth_step #(
      .WIDTH (WIDTH),
      .QW    (QW)
   ) u_step (
      .acc      (acc),
      .q        (q),
      .q_1      (q_1),
      .m        (m),
      .acc_next (acc_nx),
      .q_next   (q_nx),
      .q_1_next (q_1_nx)
   );

   always_ff @(posedge Clk) begin
      if (reset) begin
         state   <= MULT_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= '0;
         acc     <= '0;
         m       <= '0;
         q       <= '0;
         q_1     <= 1'b0;
         count   <= '0;
`ifdef MULT_UNSIGNED_EN
         unsigned_q <= 1'b0;
`endif
      end else begin
         unique case (state)
            MULT_IDLE: begin
               if (start) begin
                  state <= MULT_RUN;
                  busy  <= 1'b1;
                  m     <= m_load;
                  q     <= q_load;
                  acc   <= '0;
                  q_1   <= 1'b0;
                  count <= '0;
`ifdef MULT_UNSIGNED_EN
                  unsigned_q <= is_unsigned;
`endif
               end
            end
            MULT_RUN: begin
               acc   <= acc_nx;
               q     <= q_nx;
               q_1   <= q_1_nx;
               count <= count + 1'b1;
               if (count == last_count) begin
                  state   <= MULT_DONE;
                  done    <= 1'b1;
                  product <= prod_nx;
               end
            end
            MULT_DONE: begin
               state <= MULT_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
            default: begin
               state <= MULT_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule : booth_mult_unit
